serial_subtractor: RTL

Bit-serial N-bit subtractor computing `diff = a - b - bin` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the team's combinational full-adder datapath. It is intended for area-constrained arithmetic paths where WIDTH-cycle latency is acceptable. Operands are captured on a start handshake, and the result is presented with a one-cycle `done` pulse.

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// ============================================================================
// Module   : serial_arith_pkg
// Purpose  : Shared state encoding and counter sizing for bit-serial arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bit counter width; a single bit is enough for the two-bit minimum width.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
// Module   : full_subtractor
// Purpose  : Single-bit combinational subtractor cell: d = a - b - bi.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] d_sr_q, d_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             fs_d, fs_bo;

   full_subtractor u_cell (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .bi (br_q),
      .d  (fs_d),
      .bo (fs_bo)
   );

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      d_sr_d  = d_sr_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               a_sr_d  = a;
               b_sr_d  = b;
               br_d    = bin;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            d_sr_d = {fs_d, d_sr_q[WIDTH-1:1]};
            br_d   = fs_bo;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               diff_d  = {fs_d, d_sr_q[WIDTH-1:1]};
               bout_d  = fs_bo;
               // br_q is the borrow into the MSB at this point
               ovf_d   = br_q ^ fs_bo;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         d_sr_q  <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         d_sr_q  <= d_sr_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

`default_nettype wire
